// File: rtl/sparc_mem_pkg.sv
// Shared definitions for the SPARC memory-access sequencer: op3 codes, FSM
// states, access sizes and the op3 decode / store-byte selection helpers.
package sparc_mem_pkg;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef struct packed {
    size_e size;
    logic  is_store;
    logic  is_signed;
    logic  legal;
  } op_info_t;

  function automatic op_info_t op3_to_size(input logic [5:0] op3);
    op_info_t info;
    info = '{size: SZ_B, is_store: 1'b0, is_signed: 1'b0, legal: 1'b1};
    case (op3)
      OP_LD:   info.size = SZ_W;
      OP_LDUB: info.size = SZ_B;
      OP_LDUH: info.size = SZ_H;
      OP_LDSB: begin info.size = SZ_B; info.is_signed = 1'b1; end
      OP_LDSH: begin info.size = SZ_H; info.is_signed = 1'b1; end
      OP_ST:   begin info.size = SZ_W; info.is_store = 1'b1; end
      OP_STB:  begin info.size = SZ_B; info.is_store = 1'b1; end
      OP_STH:  begin info.size = SZ_H; info.is_store = 1'b1; end
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

  // Index of the final byte cycle for an access size.
  function automatic logic [1:0] last_idx(input size_e sz);
    logic [1:0] idx;
    case (sz)
      SZ_B:    idx = 2'd0;
      SZ_H:    idx = 2'd1;
      SZ_W:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Big-endian: byte idx of an N-byte store is taken MSB first from the low N bytes.
  function automatic logic [7:0] store_byte(input logic [31:0] data, input size_e sz,
                                            input logic [1:0] idx);
    logic [1:0] sel;
    logic [7:0] b;
    sel = last_idx(sz) - idx;
    case (sel)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      2'd3:    b = data[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Load-result extension: takes the big-endian assembled raw bytes and produces
// the 32-bit sign- or zero-extended value for the MDR.
module mem_load_extend
  import sparc_mem_pkg::*;
(
  input  size_e       size,
  input  logic        is_signed,
  input  logic [31:0] raw,
  output logic [31:0] rdata
);

  // Loaded bytes sit right-justified in raw; extend from the top loaded bit.
  always_comb begin
    rdata = 32'd0;
    case (size)
      SZ_B:    rdata = {{24{is_signed & raw[7]}}, raw[7:0]};
      SZ_H:    rdata = {{16{is_signed & raw[15]}}, raw[15:0]};
      SZ_W:    rdata = raw;
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-access sequencer: runs 1-4 big-endian byte cycles to a byte-wide RAM
// for SPARC loads/stores, then pulses MFC. Build option MEM_ALIGN_TRAP_EN
// turns misaligned halfword/word accesses into traps instead of masking.
module mem_access_unit
  import sparc_mem_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              RAM_enable,
  input  logic [5:0]        RAM_OpCode,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              MFC,
  output logic              busy,
  output logic              misaligned,
  output logic              illegal_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  state_e            state_r;
  size_e             size_r;
  logic              is_store_r;
  logic              is_signed_r;
  logic [ADDR_W-1:0] base_r;
  logic [31:0]       wdata_r;
  logic [31:0]       raw_r;
  logic [1:0]        idx_r;

  op_info_t          req_info_s;
  logic [ADDR_W-1:0] req_addr_s;
  logic              req_mis_s;
  logic [1:0]        idx_next_s;
  logic [ADDR_W-1:0] step_addr_s;
  logic [31:0]       raw_next_s;
  logic [31:0]       ext_s;
  logic              unused_s;

  assign req_info_s  = op3_to_size(RAM_OpCode);
  assign idx_next_s  = idx_r + 2'd1;
  assign step_addr_s = base_r + {{(ADDR_W-2){1'b0}}, idx_next_s};
  assign raw_next_s  = {raw_r[23:0], mem_rdata};
  assign unused_s    = ^{addr[31:ADDR_W], raw_r[31:24]};

  // Request address and alignment decode for the access being offered.
  always_comb begin
    req_addr_s = addr[ADDR_W-1:0];
    req_mis_s  = 1'b0;
`ifdef MEM_ALIGN_TRAP_EN
    if (req_info_s.legal && (req_info_s.size == SZ_H)) begin
      req_mis_s = addr[0];
    end else if (req_info_s.legal && (req_info_s.size == SZ_W)) begin
      req_mis_s = |addr[1:0];
    end else begin
      req_mis_s = 1'b0;
    end
`else
    if (req_info_s.size == SZ_H) begin
      req_addr_s[0] = 1'b0;
    end else if (req_info_s.size == SZ_W) begin
      req_addr_s[1:0] = 2'b00;
    end else begin
      req_addr_s = addr[ADDR_W-1:0];
    end
`endif
  end

  mem_load_extend u_extend (
    .size      (size_r),
    .is_signed (is_signed_r),
    .raw       (raw_next_s),
    .rdata     (ext_s)
  );

  // Sequencer FSM; every output is registered and set up for the cycle it belongs to.
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      state_r     <= IDLE;
      size_r      <= SZ_B;
      is_store_r  <= 1'b0;
      is_signed_r <= 1'b0;
      base_r      <= {ADDR_W{1'b0}};
      wdata_r     <= 32'd0;
      raw_r       <= 32'd0;
      idx_r       <= 2'd0;
      rdata       <= 32'd0;
      MFC         <= 1'b0;
      busy        <= 1'b0;
      misaligned  <= 1'b0;
      illegal_op  <= 1'b0;
      mem_addr    <= {ADDR_W{1'b0}};
      mem_wdata   <= 8'd0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          MFC        <= 1'b0;
          misaligned <= 1'b0;
          illegal_op <= 1'b0;
          mem_we     <= 1'b0;
          mem_re     <= 1'b0;
          if (RAM_enable) begin
            size_r      <= req_info_s.size;
            is_store_r  <= req_info_s.is_store;
            is_signed_r <= req_info_s.is_signed;
            base_r      <= req_addr_s;
            wdata_r     <= wdata;
            raw_r       <= 32'd0;
            idx_r       <= 2'd0;
            busy        <= 1'b1;
            if (!req_info_s.legal || req_mis_s) begin
              // Traps skip the RAM entirely and report straight from DONE.
              state_r    <= DONE;
              MFC        <= 1'b1;
              illegal_op <= ~req_info_s.legal;
              misaligned <= req_mis_s;
            end else begin
              state_r   <= XFER;
              mem_addr  <= req_addr_s;
              mem_we    <= req_info_s.is_store;
              mem_re    <= ~req_info_s.is_store;
              mem_wdata <= req_info_s.is_store ?
                           store_byte(wdata, req_info_s.size, 2'd0) : 8'd0;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        XFER: begin
          // RAM answers one cycle late, so byte idx-1 arrives during byte idx.
          if (!is_store_r && (idx_r != 2'd0)) begin
            raw_r <= raw_next_s;
          end
          if (idx_r == last_idx(size_r)) begin
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_wdata <= 8'd0;
            mem_addr  <= {ADDR_W{1'b0}};
            if (is_store_r) begin
              state_r <= DONE;
              MFC     <= 1'b1;
            end else begin
              state_r <= DRAIN;
            end
          end else begin
            idx_r     <= idx_next_s;
            mem_addr  <= step_addr_s;
            mem_wdata <= is_store_r ? store_byte(wdata_r, size_r, idx_next_s) : 8'd0;
          end
        end
        DRAIN: begin
          raw_r   <= raw_next_s;
          rdata   <= ext_s;
          state_r <= DONE;
          MFC     <= 1'b1;
        end
        DONE: begin
          MFC        <= 1'b0;
          misaligned <= 1'b0;
          illegal_op <= 1'b0;
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          MFC     <= 1'b0;
          mem_we  <= 1'b0;
          mem_re  <= 1'b0;
        end
      endcase
    end
  end

endmodule
